// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the M-stage load/store unit: FSM state,
// access size decode and timeout counter sizing.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic int tmo_cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Unused funct3 encodings fall through to a word access.
    function automatic access_size_t access_size(input logic [2:0] f3, input logic we);
        access_size_t sz;
        sz = SZ_WORD;
        if (we) begin
            case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Single-outstanding data-memory handshake between the LSU (master) and
// the data memory (slave).
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata, dmem_err
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte-enables/replication, load extraction
// and extension, misalignment detect (only with LSU_MISALIGN_TRAP_EN).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic        st_we,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    access_size_t st_size;
    access_size_t ld_size;
    logic         sext;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;

    assign st_size = access_size(st_funct3, st_we);
    assign ld_size = access_size(ld_funct3, 1'b0);
    assign sext    = ~ld_funct3[2];

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((st_size == SZ_HALF) && st_addr_lo[0]) ||
                      ((st_size == SZ_WORD) && (st_addr_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
    end

    assign ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (ld_size)
            SZ_BYTE: load_data = {{24{sext & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = {{16{sext & ld_half[15]}}, ld_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: issues one aligned, byte-enabled data-memory access
// per instruction and stalls the pipeline until it completes.
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN (see lsu_align).
//
// state | meaning
// IDLE  | no access outstanding; a new access is latched and issued here
// BUSY  | request on the bus, waiting for ack or timeout
// DONE  | result registered, pipeline released for one cycle
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_m,
    input  logic            MemRead_m,
    input  logic            MemWrite_m,
    input  logic [2:0]      funct3_m,
    input  logic [31:0]     ALUResult_m,
    input  logic [31:0]     WriteData_m,
    output logic            stall_m,
    output logic [31:0]     ReadData_m,
    output logic            bus_err_m,
    output logic            misalign_m,
    mem_stage_lsu_if.master dmem
);

    localparam int CW        = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam int TC_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TC_LAST = TC_LAST_I[CW-1:0];

    lsu_state_t  state;
    lsu_state_t  state_nxt;
    logic        access;
    logic        issue;
    logic        tmo_hit;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  be_a;
    logic [31:0] wdata_a;
    logic [31:0] load_a;
    logic        misalign_a;

    assign access  = valid_m & (MemRead_m | MemWrite_m);
    assign issue   = (state == ST_IDLE) & access & ~misalign_a;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TC_LAST);

    lsu_align u_align (
        .st_funct3  (funct3_m),
        .st_we      (MemWrite_m),
        .st_addr_lo (ALUResult_m[1:0]),
        .st_data    (WriteData_m),
        .be         (be_a),
        .wdata      (wdata_a),
        .misalign   (misalign_a),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (addr_lo_q),
        .rdata      (dmem.dmem_rdata),
        .load_data  (load_a)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = ST_BUSY;
            ST_BUSY: if (dmem.dmem_ack || tmo_hit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_m    = 1'b0;
        misalign_m = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    stall_m    = issue;
                    misalign_m = access & misalign_a;
                end
                ST_BUSY: stall_m = 1'b1;
                default: stall_m = 1'b0;
            endcase
        end
    end

    // Request fields are frozen for the whole BUSY phase; ack wins over timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_be    <= '0;
            ReadData_m      <= '0;
            bus_err_m       <= 1'b0;
            tmo_cnt         <= '0;
            funct3_q        <= '0;
            addr_lo_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (issue) begin
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= MemWrite_m;
                        dmem.dmem_addr  <= {ALUResult_m[31:2], 2'b00};
                        dmem.dmem_wdata <= wdata_a;
                        dmem.dmem_be    <= be_a;
                        funct3_q        <= funct3_m;
                        addr_lo_q       <= ALUResult_m[1:0];
                    end else if (access & misalign_a) begin
                        ReadData_m <= '0;
                        bus_err_m  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        ReadData_m    <= dmem.dmem_err ? 32'd0 : load_a;
                        bus_err_m     <= dmem.dmem_err;
                    end else if (tmo_hit) begin
                        dmem.dmem_req <= 1'b0;
                        ReadData_m    <= '0;
                        bus_err_m     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a default-timeout instance for the main
// access patterns and a TIMEOUT_CYCLES=3 instance for abort behaviour.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_m = 1'b0;
    logic        valid_t = 1'b0;
    logic        MemRead_m = 1'b0;
    logic        MemWrite_m = 1'b0;
    logic [2:0]  funct3_m = 3'b000;
    logic [31:0] ALUResult_m = 32'd0;
    logic [31:0] WriteData_m = 32'd0;

    logic        stall_m, bus_err_m, misalign_m;
    logic [31:0] ReadData_m;
    logic        stall_t, bus_err_t, misalign_t;
    logic [31:0] read_data_t;

    int n_chk = 0;
    int n_pass = 0;

    mem_stage_lsu_if bus ();
    mem_stage_lsu_if bus_t ();

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m),
        .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m), .funct3_m(funct3_m),
        .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m),
        .stall_m(stall_m), .ReadData_m(ReadData_m), .bus_err_m(bus_err_m),
        .misalign_m(misalign_m), .dmem(bus)
    );

    mem_stage_lsu #(.TIMEOUT_CYCLES(3)) dut_t (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_t),
        .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m), .funct3_m(funct3_m),
        .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m),
        .stall_m(stall_t), .ReadData_m(read_data_t), .bus_err_m(bus_err_t),
        .misalign_m(misalign_t), .dmem(bus_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int waits, input logic err,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                              input logic [31:0] exp_rd, input logic exp_err);
        int stalls;
        int busy;
        bit fields_ok;
        bit done;
        stalls = 0; busy = 0; fields_ok = 1'b1; done = 1'b0;
        @(negedge clk);
        valid_m = 1'b1; MemRead_m = rd; MemWrite_m = wr; funct3_m = f3;
        ALUResult_m = addr; WriteData_m = wd;
        #1;
        chk({tag, "_idle_stall"}, 32'(stall_m), 32'd1);
        chk({tag, "_idle_misalign"}, 32'(misalign_m), 32'd0);
        if (stall_m) stalls++;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            bus.dmem_ack = 1'b0; bus.dmem_err = 1'b0; bus.dmem_rdata = 32'hDEAD_BEEF;
            if (stall_m) stalls++;
            if (bus.dmem_req) begin
                busy++;
                if (bus.dmem_we !== wr || bus.dmem_addr !== exp_addr ||
                    bus.dmem_wdata !== exp_wdata || bus.dmem_be !== exp_be)
                    fields_ok = 1'b0;
                if (busy == waits + 1) begin
                    bus.dmem_ack = 1'b1; bus.dmem_err = err; bus.dmem_rdata = rdata;
                end
            end else begin
                done = 1'b1;
                valid_m = 1'b0; MemRead_m = 1'b0; MemWrite_m = 1'b0;
            end
        end
        valid_m = 1'b0;
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(waits + 2));
        chk({tag, "_req_fields"}, 32'(fields_ok), 32'd1);
        chk({tag, "_rdata"}, ReadData_m, exp_rd);
        chk({tag, "_bus_err"}, 32'(bus_err_m), 32'(exp_err));
    endtask

    initial begin
        int busy;
        bit done;
        bus.dmem_ack = 1'b0; bus.dmem_err = 1'b0; bus.dmem_rdata = 32'hDEAD_BEEF;
        bus_t.dmem_ack = 1'b0; bus_t.dmem_err = 1'b0; bus_t.dmem_rdata = 32'hDEAD_BEEF;

        // reset with an access presented: stall/misalign forced low
        valid_m = 1'b1; MemRead_m = 1'b1; funct3_m = 3'b010; ALUResult_m = 32'h101;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall_m), 32'd0);
        chk("rst_misalign", 32'(misalign_m), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_addr", bus.dmem_addr, 32'd0);
        chk("rst_wdata", bus.dmem_wdata, 32'd0);
        chk("rst_be", 32'(bus.dmem_be), 32'd0);
        chk("rst_rdata", ReadData_m, 32'd0);
        chk("rst_bus_err", 32'(bus_err_m), 32'd0);
        chk("rst_t_stall", 32'(stall_t | misalign_t), 32'd0);
        valid_m = 1'b0; MemRead_m = 1'b0;
        rst_n = 1'b1;

        //          tag    rd    wr    f3      addr          wdata         w  err   rdata          exp_addr      exp_wdata     be       exp_rd        err
        run_access("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 1'b0, 32'h0,         32'h0000_0100, 32'hABAB_ABAB, 4'b1000, 32'h0000_0000, 1'b0);
        run_access("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,         0, 1'b0, 32'h0080_0000, 32'h0000_0100, 32'h0,         4'b0100, 32'hFFFF_FF80, 1'b0);
        run_access("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,         0, 1'b0, 32'h0080_0000, 32'h0000_0100, 32'h0,         4'b0100, 32'h0000_0080, 1'b0);
        run_access("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,         4, 1'b0, 32'h8001_0000, 32'h0000_0000, 32'h0,         4'b1100, 32'hFFFF_8001, 1'b0);
        run_access("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h1234_5678, 1, 1'b0, 32'h0,         32'h0000_0004, 32'h5678_5678, 4'b1100, 32'h0000_0000, 1'b0);
        run_access("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,         0, 1'b0, 32'h1234_F00D, 32'h0000_0000, 32'h0,         4'b0011, 32'h0000_F00D, 1'b0);
        run_access("sw",   1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,         32'h0000_0200, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0);
        run_access("lw_err", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,       2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0300, 32'h0,         4'b1111, 32'h0000_0000, 1'b1);
        run_access("ld_f3_110", 1'b1, 1'b0, 3'b110, 32'h0000_0020, 32'h0,    0, 1'b0, 32'h8765_4321, 32'h0000_0020, 32'h0,         4'b1111, 32'h8765_4321, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        valid_m = 1'b1; MemRead_m = 1'b1; funct3_m = 3'b010; ALUResult_m = 32'h101;
        #1;
        chk("mis_flag", 32'(misalign_m), 32'd1);
        chk("mis_stall", 32'(stall_m), 32'd0);
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dmem_req) done = 1'b1;
        end
        chk("mis_no_req", 32'(done), 32'd0);
        chk("mis_rdata", ReadData_m, 32'd0);
        valid_m = 1'b0; MemRead_m = 1'b0;
`else
        run_access("lw_unal", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,      0, 1'b0, 32'h5566_7788, 32'h0000_0100, 32'h0,         4'b1111, 32'h5566_7788, 1'b0);
`endif
        run_access("lw",   1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         0, 1'b0, 32'h1122_3344, 32'h0000_0010, 32'h0,         4'b1111, 32'h1122_3344, 1'b0);

        // timeout instance: one good load, then an access that is never acked
        @(negedge clk);
        valid_t = 1'b1; MemRead_m = 1'b1; funct3_m = 3'b010; ALUResult_m = 32'h44;
        @(negedge clk);
        chk("t_req", 32'(bus_t.dmem_req), 32'd1);
        chk("t_addr", bus_t.dmem_addr, 32'h44);
        bus_t.dmem_ack = 1'b1; bus_t.dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_t.dmem_ack = 1'b0; valid_t = 1'b0;
        chk("t_ok_rdata", read_data_t, 32'hCAFE_F00D);
        chk("t_ok_err", 32'(bus_err_t), 32'd0);
        @(negedge clk);
        valid_t = 1'b1; ALUResult_m = 32'h48;
        #1;
        chk("t_idle_stall", 32'(stall_t), 32'd1);
        busy = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus_t.dmem_req) busy++;
            else if (busy > 0) done = 1'b1;
        end
        valid_t = 1'b0; MemRead_m = 1'b0;
        chk("t_completed", 32'(done), 32'd1);
        chk("t_busy_cycles", 32'(busy), 32'd3);
        chk("t_rdata", read_data_t, 32'd0);
        chk("t_bus_err", 32'(bus_err_t), 32'd1);
        chk("t_done_stall", 32'(stall_t), 32'd0);

        // reset while BUSY
        @(negedge clk);
        valid_m = 1'b1; MemRead_m = 1'b1; funct3_m = 3'b010; ALUResult_m = 32'h80;
        @(negedge clk);
        chk("rb_busy_req", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rb_req", 32'(bus.dmem_req), 32'd0);
        chk("rb_we", 32'(bus.dmem_we), 32'd0);
        chk("rb_addr", bus.dmem_addr, 32'd0);
        chk("rb_be", 32'(bus.dmem_be), 32'd0);
        chk("rb_wdata", bus.dmem_wdata, 32'd0);
        chk("rb_rdata", ReadData_m, 32'd0);
        chk("rb_bus_err", 32'(bus_err_m), 32'd0);
        chk("rb_stall", 32'(stall_m), 32'd0);
        rst_n = 1'b1; valid_m = 1'b0; MemRead_m = 1'b0;
        run_access("lb_post_rst", 1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0,  1, 1'b0, 32'h0000_7F00, 32'h0000_0000, 32'h0,         4'b0010, 32'h0000_007F, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the memory (M) stage of the pipelined RV32I core, between the E/M and M/W pipeline registers. It turns the M-stage address, store data and funct3 into an aligned, byte-enabled request on a single-outstanding data-memory handshake. It holds the pipeline with `stall_m` until the access completes. It produces the sign- or zero-extended `ReadData_m` consumed by the M/W register.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of BUSY cycles without `dmem_ack` before the access is aborted. 0 disables the timeout.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`
- `valid_m`  in  1  M stage holds a real instruction
- `MemRead_m`  in  1  load
- `MemWrite_m`  in  1  store
- `funct3_m`  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `ALUResult_m`  in  32  byte address
- `WriteData_m`  in  32  store data (rs2)
- `stall_m`  out  1  hold F/D/E/M stages; M/W register clears (bubble)
- `ReadData_m`  out  32  extended load data, valid in DONE
- `bus_err_m`  out  1  access ended in error or timeout, valid in DONE
- `misalign_m`  out  1  misaligned access detected (tied 0 without macro)
- `dmem_req`  out  1  request, held until ack
- `dmem_we`  out  1  write
- `dmem_addr`  out  32  word address, bits [1:0] = 0
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables
- `dmem_ack`  in  1  access complete, one cycle
- `dmem_rdata`  in  32  read word, valid with ack
- `dmem_err`  in  1  error, valid with ack

## Operation
- An access is `valid_m & (MemRead_m | MemWrite_m)`. If both read and write are set, the access is a store.
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - On an access: `stall_m`=1 (combinational). Latch address, lanes, be and we. Go to BUSY.
  - Otherwise `stall_m`=0.
- **BUSY**
  - `dmem_req`=1, `stall_m`=1. Request fields stay stable.
  - Timeout counter increments each cycle.
  - On `dmem_ack`: capture extracted read data, or 0 if `dmem_err`. Set `bus_err_m`=`dmem_err`. Go to DONE.
  - Counter reaching `TIMEOUT_CYCLES` with no ack: drop `dmem_req`, `ReadData_m`=0, `bus_err_m`=1, go to DONE.
- **DONE**
  - `stall_m`=0, so the instruction advances into M/W at the clock edge. Go to IDLE.
  - `ReadData_m` and `bus_err_m` hold until the next DONE.
- **Store lanes**, with a = addr[1:0]:
  - SB: `be` = 1<<a, `wdata` = {4{rs2[7:0]}}.
  - SH: `be` = a[1] ? 1100 : 0011, `wdata` = {2{rs2[15:0]}}.
  - SW: `be` = 1111.
- **Load extract**
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: half a[1].
  - LW: whole word.
- **Unused funct3:** load 011/110/111 and store x11 are treated as word accesses.
- M-stage instructions are never flushed, so there is no clear input. An issued store always completes.
- **Reset mid-BUSY:** the next cycle is IDLE with `dmem_req`=0. The memory side tolerates a withdrawn request.

## Timing
- Reset values: `dmem_req`/`dmem_we`=0, `dmem_addr`/`dmem_wdata`=0, `dmem_be`=0, `ReadData_m`=0, `bus_err_m`=0, state IDLE. `stall_m` and `misalign_m` are forced to 0 while `rst_n`=0.
- `dmem_*`, `ReadData_m` and `bus_err_m` are registered.
- Minimum access latency is 3 cycles (IDLE, BUSY with same-cycle ack, DONE), with 2 stall cycles. Each extra wait cycle adds one.
- With `TIMEOUT_CYCLES`=N, the abort happens after N BUSY cycles.
- A back-to-back access in the next IDLE cycle starts a new transaction; no cycle is lost beyond the FSM.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - **Defined:** misaligned accesses are detected (half with a[0]=1, word with a≠0). In IDLE, such an access sets `misalign_m`=1 combinationally, issues no request, keeps `stall_m`=0, and leaves `ReadData_m` at 0 in the next cycle. The trap handler consumes `misalign_m`.
  - **Undefined:** low address bits that do not fit the access size are ignored (half uses a[1], word ignores a). `misalign_m` is tied to 0.

## Structure
- Package `lsu_pkg`:
  - FSM state enum `lsu_state_t`.
  - funct3 localparams `F3_LB`…`F3_SW`.
  - Timeout counter width function, $clog2(TIMEOUT_CYCLES+1), min 1.
- Sub-module `lsu_align` (combinational):
  - store lane/be generation;
  - load byte/half extraction and extension;
  - misalignment detect.

## Test plan
- SB at addr 0x103, rs2=0xAB, ack in BUSY → `dmem_addr`=0x100, `be`=1000, `wdata`=0xABABABAB, `stall_m` high 2 cycles.
- LB at 0x102, `rdata`=0x0080_0000 → `ReadData_m`=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH at 0x002, `rdata`=0x8001_0000, ack delayed 4 cycles → `ReadData_m`=0xFFFF8001, stall held 6 cycles, request fields stable throughout.
- `TIMEOUT_CYCLES`=3, no ack → `dmem_req` drops after 3 BUSY cycles, `bus_err_m`=1, `ReadData_m`=0. `dmem_err`+ack → same outputs.
- LW at 0x101 → with the macro: `misalign_m`=1, `dmem_req` never asserted. Without it: read from 0x100.
- `rst_n` low during BUSY → next cycle `dmem_req`=0, all outputs at reset values. The next load after reset completes normally.
